analog_switch_seq: RTL and testbench

//  Sequences PCI-side requests for analog switch settings onto the switch controls with break-before-make timing.

---
 rtl/analog_switch_seq_pkg.sv | 19 +
 rtl/analog_switch_seq_if.sv | 26 ++
 rtl/analog_switch_seq_sel.sv | 20 ++
 rtl/analog_switch_seq.sv | 173 +++++++++++++++++
 tb/tb_analog_switch_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/analog_switch_seq_pkg.sv
// Shared types and constants for the analog switch sequencer.
// Field widths, FSM state encoding and the safe (all-open) switch settings.
package analog_sw_pkg;

  localparam int unsigned PUD_W = 4;
  localparam int unsigned TR_W  = 3;
  localparam int unsigned LP_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    MAKE_SETTLE
  } sw_state_e;

  localparam logic [PUD_W-1:0] PUD_SAFE = '0;
  localparam logic [TR_W-1:0]  TR_SAFE  = '0;
  localparam logic [LP_W-1:0]  LP_SAFE  = '0;

endpackage

// File: rtl/analog_switch_seq_if.sv
// Request/status bundle between the PCI register block and the switch sequencer.
// Signal suffixes are from the sequencer's point of view.
interface analog_switch_seq_if;

  logic                           cfg_wr_i;
  logic [analog_sw_pkg::PUD_W-1:0] pud_sel_i;
  logic [analog_sw_pkg::TR_W-1:0]  tr_sel_i;
  logic [analog_sw_pkg::LP_W-1:0]  lp_sel_i;
  logic                           busy_o;
  logic                           done_o;
  logic                           rej_o;
  logic [analog_sw_pkg::PUD_W-1:0] rb_pud_o;
  logic [analog_sw_pkg::TR_W-1:0]  rb_tr_o;
  logic [analog_sw_pkg::LP_W-1:0]  rb_lp_o;

  modport master (
    output cfg_wr_i, pud_sel_i, tr_sel_i, lp_sel_i,
    input  busy_o, done_o, rej_o, rb_pud_o, rb_tr_o, rb_lp_o
  );

  modport slave (
    input  cfg_wr_i, pud_sel_i, tr_sel_i, lp_sel_i,
    output busy_o, done_o, rej_o, rb_pud_o, rb_tr_o, rb_lp_o
  );

endinterface

// File: rtl/analog_switch_seq_sel.sv
// Switch setting to switch drive mapping (purely combinational).
// The top pud bit drives both legs of the lvds pair; loop N is the complement of loop P.
module analog_switch_sel
  import analog_sw_pkg::*;
(
  input  logic [PUD_W-1:0] pud_sel_i,
  input  logic [TR_W-1:0]  tr_sel_i,
  input  logic [LP_W-1:0]  lp_sel_i,
  output logic [PUD_W:0]   pud_ctr_o,
  output logic [TR_W-1:0]  tr_ctr_o,
  output logic [LP_W-1:0]  lph_ctr_o,
  output logic [LP_W-1:0]  lpl_ctr_o
);

  assign pud_ctr_o = {pud_sel_i[PUD_W-1], pud_sel_i};
  assign tr_ctr_o  = tr_sel_i;
  assign lph_ctr_o = lp_sel_i;
  assign lpl_ctr_o = ~lp_sel_i;

endmodule

// File: rtl/analog_switch_seq.sv
// Break-before-make sequencer: applies PCI switch requests to the switch drives,
// opening dropped switches first, closing new ones after BREAK_CYC, reporting done after SETTLE_CYC.
module analog_switch_seq
  import analog_sw_pkg::*;
#(
  parameter int unsigned BREAK_CYC  = 100,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  analog_switch_seq_if.slave   cfg,
  output logic [PUD_W:0]       pud_ctr_o,
  output logic [TR_W-1:0]      tr_ctr_o,
  output logic [LP_W-1:0]      lph_ctr_o,
  output logic [LP_W-1:0]      lpl_ctr_o
);

  localparam logic [CNT_W-1:0] BREAK_LD  = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  sw_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;

  logic [PUD_W-1:0] r_app_pud, w_app_pud_nxt, r_tgt_pud, w_tgt_pud_nxt, r_rb_pud, w_rb_pud_nxt;
  logic [TR_W-1:0]  r_app_tr,  w_app_tr_nxt,  r_tgt_tr,  w_tgt_tr_nxt,  r_rb_tr,  w_rb_tr_nxt;
  logic [LP_W-1:0]  r_app_lp,  w_app_lp_nxt,  r_tgt_lp,  w_tgt_lp_nxt,  r_rb_lp,  w_rb_lp_nxt;

  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_rej,  w_rej_nxt;

  logic [PUD_W:0]  r_pud_ctr, w_pud_ctr;
  logic [TR_W-1:0] r_tr_ctr,  w_tr_ctr;
  logic [LP_W-1:0] r_lph_ctr, w_lph_ctr;
  logic [LP_W-1:0] r_lpl_ctr, w_lpl_ctr;

  logic w_req_same;
  assign w_req_same = ({cfg.pud_sel_i, cfg.tr_sel_i, cfg.lp_sel_i} ==
                       {r_app_pud, r_app_tr, r_app_lp});

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_app_pud_nxt = r_app_pud;
    w_app_tr_nxt  = r_app_tr;
    w_app_lp_nxt  = r_app_lp;
    w_tgt_pud_nxt = r_tgt_pud;
    w_tgt_tr_nxt  = r_tgt_tr;
    w_tgt_lp_nxt  = r_tgt_lp;
    w_rb_pud_nxt  = r_rb_pud;
    w_rb_tr_nxt   = r_rb_tr;
    w_rb_lp_nxt   = r_rb_lp;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_rej_nxt     = 1'b0;

    if (r_state != IDLE && cfg.cfg_wr_i)
      w_rej_nxt = 1'b1;

    case (r_state)
      IDLE: begin
        if (cfg.cfg_wr_i) begin
          w_tgt_pud_nxt = cfg.pud_sel_i;
          w_tgt_tr_nxt  = cfg.tr_sel_i;
          w_tgt_lp_nxt  = cfg.lp_sel_i;
          if (w_req_same) begin
            w_done_nxt = 1'b1;
          end else begin
            // Break: only switches going 1->0 open now.
            w_app_pud_nxt = r_app_pud & cfg.pud_sel_i;
            w_app_tr_nxt  = r_app_tr  & cfg.tr_sel_i;
            w_app_lp_nxt  = r_app_lp  & cfg.lp_sel_i;
            w_busy_nxt    = 1'b1;
            w_timer_nxt   = BREAK_LD;
            w_state_nxt   = BREAK;
          end
        end
      end
      BREAK: begin
        if (r_timer == '0) begin
          w_app_pud_nxt = r_tgt_pud;
          w_app_tr_nxt  = r_tgt_tr;
          w_app_lp_nxt  = r_tgt_lp;
          w_rb_pud_nxt  = r_tgt_pud;
          w_rb_tr_nxt   = r_tgt_tr;
          w_rb_lp_nxt   = r_tgt_lp;
          w_timer_nxt   = SETTLE_LD;
          w_state_nxt   = MAKE_SETTLE;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      MAKE_SETTLE: begin
        if (r_timer == '0) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Mapping is fed from the next applied value so the registered drives
  // change in the same cycle as the applied registers.
  analog_switch_sel u_sel (
    .pud_sel_i (w_app_pud_nxt),
    .tr_sel_i  (w_app_tr_nxt),
    .lp_sel_i  (w_app_lp_nxt),
    .pud_ctr_o (w_pud_ctr),
    .tr_ctr_o  (w_tr_ctr),
    .lph_ctr_o (w_lph_ctr),
    .lpl_ctr_o (w_lpl_ctr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_app_pud <= PUD_SAFE;
      r_app_tr  <= TR_SAFE;
      r_app_lp  <= LP_SAFE;
      r_tgt_pud <= PUD_SAFE;
      r_tgt_tr  <= TR_SAFE;
      r_tgt_lp  <= LP_SAFE;
      r_rb_pud  <= PUD_SAFE;
      r_rb_tr   <= TR_SAFE;
      r_rb_lp   <= LP_SAFE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rej     <= 1'b0;
      r_pud_ctr <= '0;
      r_tr_ctr  <= '0;
      r_lph_ctr <= '0;
      r_lpl_ctr <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_app_pud <= w_app_pud_nxt;
      r_app_tr  <= w_app_tr_nxt;
      r_app_lp  <= w_app_lp_nxt;
      r_tgt_pud <= w_tgt_pud_nxt;
      r_tgt_tr  <= w_tgt_tr_nxt;
      r_tgt_lp  <= w_tgt_lp_nxt;
      r_rb_pud  <= w_rb_pud_nxt;
      r_rb_tr   <= w_rb_tr_nxt;
      r_rb_lp   <= w_rb_lp_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rej     <= w_rej_nxt;
      r_pud_ctr <= w_pud_ctr;
      r_tr_ctr  <= w_tr_ctr;
      r_lph_ctr <= w_lph_ctr;
      r_lpl_ctr <= w_lpl_ctr;
    end
  end

  assign cfg.busy_o   = r_busy;
  assign cfg.done_o   = r_done;
  assign cfg.rej_o    = r_rej;
  assign cfg.rb_pud_o = r_rb_pud;
  assign cfg.rb_tr_o  = r_rb_tr;
  assign cfg.rb_lp_o  = r_rb_lp;

  assign pud_ctr_o = r_pud_ctr;
  assign tr_ctr_o  = r_tr_ctr;
  assign lph_ctr_o = r_lph_ctr;
  assign lpl_ctr_o = r_lpl_ctr;

endmodule

// File: tb/tb_analog_switch_seq.sv
// Directed bench for analog_switch_seq with BREAK_CYC=4, SETTLE_CYC=8.
// Cycle k is observed 1 time unit after the k-th rising edge following the request strobe.
module tb_analog_switch_seq;

  logic       clk;
  logic       rst_n;
  logic [4:0] pud_ctr;
  logic [2:0] tr_ctr;
  logic [3:0] lph_ctr;
  logic [3:0] lpl_ctr;

  int total = 0;
  int bad   = 0;

  analog_switch_seq_if u_if ();

  analog_switch_seq #(
    .BREAK_CYC  (4),
    .SETTLE_CYC (8),
    .CNT_W      (16)
  ) u_dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .cfg       (u_if.slave),
    .pud_ctr_o (pud_ctr),
    .tr_ctr_o  (tr_ctr),
    .lph_ctr_o (lph_ctr),
    .lpl_ctr_o (lpl_ctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] p, input logic [2:0] t, input logic [3:0] l);
    u_if.pud_sel_i = p;
    u_if.tr_sel_i  = t;
    u_if.lp_sel_i  = l;
    u_if.cfg_wr_i  = 1'b1;
    tick();
    u_if.cfg_wr_i  = 1'b0;
  endtask

  task automatic chk_drv(input string tag, input logic [4:0] p, input logic [2:0] t,
                         input logic [3:0] h, input logic [3:0] l);
    chk({tag, ".pud_ctr"}, 8'(pud_ctr), 8'(p));
    chk({tag, ".tr_ctr"},  8'(tr_ctr),  8'(t));
    chk({tag, ".lph_ctr"}, 8'(lph_ctr), 8'(h));
    chk({tag, ".lpl_ctr"}, 8'(lpl_ctr), 8'(l));
  endtask

  // Walks cycles 1..14 of a sequence whose strobe has just been issued.
  task automatic watch_seq(input string tag,
                           input logic [4:0] bp, input logic [2:0] bt, input logic [3:0] bh, input logic [3:0] bl,
                           input logic [4:0] mp, input logic [2:0] mt, input logic [3:0] mh, input logic [3:0] ml,
                           input logic [10:0] old_rb, input logic [10:0] new_rb);
    for (int k = 1; k <= 14; k++) begin
      if (k >= 5) chk_drv($sformatf("%s.c%0d.make", tag, k), mp, mt, mh, ml);
      else        chk_drv($sformatf("%s.c%0d.brk", tag, k), bp, bt, bh, bl);
      chk($sformatf("%s.c%0d.busy", tag, k), 8'(u_if.busy_o), 8'(k <= 12));
      chk($sformatf("%s.c%0d.done", tag, k), 8'(u_if.done_o), 8'(k == 13));
      chk($sformatf("%s.c%0d.rej", tag, k),  8'(u_if.rej_o),  8'h00);
      chk($sformatf("%s.c%0d.rb", tag, k),
          8'({u_if.rb_pud_o, u_if.rb_tr_o, u_if.rb_lp_o} == (k >= 5 ? new_rb : old_rb)), 8'h01);
      tick();
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.cfg_wr_i  = 1'b0;
    u_if.pud_sel_i = '0;
    u_if.tr_sel_i  = '0;
    u_if.lp_sel_i  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk_drv("reset", 5'h00, 3'h0, 4'h0, 4'hF);
    chk("reset.busy", 8'(u_if.busy_o), 8'h00);
    chk("reset.done", 8'(u_if.done_o), 8'h00);
    chk("reset.rej",  8'(u_if.rej_o),  8'h00);
    chk("reset.rb",   8'({u_if.rb_pud_o, u_if.rb_tr_o, u_if.rb_lp_o}), 8'h00);
    chk("reset.rbhi", 8'(u_if.rb_pud_o), 8'h00);

    // From safe: pud=A tr=5 lp=3, nothing closes until make.
    do_write(4'hA, 3'h5, 4'h3);
    watch_seq("first", 5'h00, 3'h0, 4'h0, 4'hF, 5'h1A, 3'h5, 4'h3, 4'hC,
              11'h000, {4'hA, 3'h5, 4'h3});

    // lp 3 -> 6: bit0 opens in break, bit2 closes in make, bit1 stays on.
    do_write(4'hA, 3'h5, 4'h6);
    watch_seq("lpchg", 5'h1A, 3'h5, 4'h2, 4'hD, 5'h1A, 3'h5, 4'h6, 4'h9,
              {4'hA, 3'h5, 4'h3}, {4'hA, 3'h5, 4'h6});

    // Request equal to applied: immediate done, no busy.
    do_write(4'hA, 3'h5, 4'h6);
    chk("same.c1.done", 8'(u_if.done_o), 8'h01);
    chk("same.c1.busy", 8'(u_if.busy_o), 8'h00);
    chk_drv("same.c1", 5'h1A, 3'h5, 4'h6, 4'h9);
    tick();
    chk("same.c2.done", 8'(u_if.done_o), 8'h00);
    chk("same.c2.busy", 8'(u_if.busy_o), 8'h00);
    chk_drv("same.c2", 5'h1A, 3'h5, 4'h6, 4'h9);
    tick();

    // Rejected write mid-sequence, then a write in the done cycle.
    do_write(4'hF, 3'h7, 4'hF);
    chk("rej.c1.busy", 8'(u_if.busy_o), 8'h01);
    chk_drv("rej.c1", 5'h1A, 3'h5, 4'h6, 4'h9);
    tick();
    tick();
    do_write(4'h0, 3'h0, 4'h0);
    chk("rej.c4.rej", 8'(u_if.rej_o), 8'h01);
    chk("rej.c4.busy", 8'(u_if.busy_o), 8'h01);
    tick();
    chk("rej.c5.rej", 8'(u_if.rej_o), 8'h00);
    chk_drv("rej.c5", 5'h1F, 3'h7, 4'hF, 4'h0);
    chk("rej.c5.rb", 8'({u_if.rb_pud_o, u_if.rb_tr_o, u_if.rb_lp_o} == {4'hF, 3'h7, 4'hF}), 8'h01);
    repeat (8) tick();
    chk("rej.c13.done", 8'(u_if.done_o), 8'h01);
    chk("rej.c13.busy", 8'(u_if.busy_o), 8'h00);
    chk_drv("rej.c13", 5'h1F, 3'h7, 4'hF, 4'h0);
    do_write(4'h0, 3'h0, 4'h0);
    watch_seq("donewr", 5'h00, 3'h0, 4'h0, 4'hF, 5'h00, 3'h0, 4'h0, 4'hF,
              {4'hF, 3'h7, 4'hF}, 11'h000);

    // Reset at cycle 6 of a sequence.
    do_write(4'h5, 3'h3, 4'h9);
    repeat (5) tick();
    chk_drv("rst.c6.pre", 5'h05, 3'h3, 4'h9, 4'h6);
    rst_n = 1'b0;
    #1;
    chk_drv("rst.async", 5'h00, 3'h0, 4'h0, 4'hF);
    chk("rst.async.busy", 8'(u_if.busy_o), 8'h00);
    chk("rst.async.rb", 8'({u_if.rb_pud_o, u_if.rb_tr_o, u_if.rb_lp_o}), 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("rst.after%0d.done", k), 8'(u_if.done_o), 8'h00);
      chk($sformatf("rst.after%0d.busy", k), 8'(u_if.busy_o), 8'h00);
    end
    do_write(4'h3, 3'h1, 4'hC);
    watch_seq("postrst", 5'h00, 3'h0, 4'h0, 4'hF, 5'h03, 3'h1, 4'hC, 4'h3,
              11'h000, {4'h3, 3'h1, 4'hC});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
